// File: rtl/muldiv_hilo_ctrl_if.sv
// EX-side bundle for the multiply/divide HI/LO unit.
// master: EX pipeline (drives requests); slave: muldiv_hilo_ctrl.
`ifndef DWIDTH
`define DWIDTH 32
`endif

interface muldiv_hilo_ctrl_if #(
  parameter int DWIDTH = `DWIDTH
);
  logic              md_i_start;
  logic [1:0]        md_i_op;
  logic [DWIDTH-1:0] md_i_data_rs;
  logic [DWIDTH-1:0] md_i_data_rt;
  logic              md_i_flush;
  logic              md_i_rd_hi;
  logic              md_i_rd_lo;
  logic              md_i_wr_hi;
  logic              md_i_wr_lo;
  logic [DWIDTH-1:0] md_i_wr_data;
  logic [DWIDTH-1:0] md_o_hi;
  logic [DWIDTH-1:0] md_o_lo;
  logic              md_o_busy;
  logic              md_o_done;
  logic              md_o_stall;

  modport master (
    output md_i_start, md_i_op, md_i_data_rs,
    output md_i_data_rt, md_i_flush,
    output md_i_rd_hi, md_i_rd_lo,
    output md_i_wr_hi, md_i_wr_lo, md_i_wr_data,
    input  md_o_hi, md_o_lo, md_o_busy,
    input  md_o_done, md_o_stall
  );

  modport slave (
    input  md_i_start, md_i_op, md_i_data_rs,
    input  md_i_data_rt, md_i_flush,
    input  md_i_rd_hi, md_i_rd_lo,
    input  md_i_wr_hi, md_i_wr_lo, md_i_wr_data,
    output md_o_hi, md_o_lo, md_o_busy,
    output md_o_done, md_o_stall
  );
endinterface

// File: rtl/muldiv_hilo_ctrl.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO; clk, sync
// active-low rst, bus (slave modport). Optional: MD_EARLY_OUT_EN.
`ifndef DWIDTH
`define DWIDTH 32
`endif

module muldiv_hilo_ctrl #(
  parameter int DWIDTH    = `DWIDTH,
  parameter int CNT_WIDTH = 6
) (
  input logic             md_i_clk,
  input logic             md_i_rst,
  muldiv_hilo_ctrl_if.slave bus
);
  localparam int W = DWIDTH;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    SIGN
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 is_div;
  logic                 neg_q;
  logic                 neg_r;
  logic                 dz;
  // mul: acc = product, mc = shifted multiplicand, mr = multiplier
  // div: acc = {remainder, dividend/quotient}, mc[W-1:0] = divisor
  logic [2*W-1:0]       acc;
  logic [2*W-1:0]       mc;
  logic [W-1:0]         mr;
  logic [W-1:0]         hi;
  logic [W-1:0]         lo;
  logic                 done;

  logic                 sgn;
  logic [W-1:0]         rs_mag;
  logic [W-1:0]         rt_mag;
  logic [W:0]           shl;
  logic [W:0]           dif;
  logic [2*W-1:0]       div_next;
  logic [2*W-1:0]       mul_next;
  logic                 last;

  always_comb begin
    sgn    = ~bus.md_i_op[0];
    rs_mag = (sgn && bus.md_i_data_rs[W-1]) ?
             -bus.md_i_data_rs : bus.md_i_data_rs;
    rt_mag = (sgn && bus.md_i_data_rt[W-1]) ?
             -bus.md_i_data_rt : bus.md_i_data_rt;
  end

  // Partial remainder is always below the divisor, so dif[W]
  // is a clean borrow flag.
  always_comb begin
    shl = {acc[2*W-1:W], acc[W-1]};
    dif = shl - {1'b0, mc[W-1:0]};
    if (!dif[W])
      div_next = {dif[W-1:0], acc[W-2:0], 1'b1};
    else
      div_next = {shl[W-1:0], acc[W-2:0], 1'b0};
    mul_next = mr[0] ? acc + mc : acc;
  end

  always_comb begin
    last = (cnt == CNT_WIDTH'(W - 1));
`ifdef MD_EARLY_OUT_EN
    // Stop once no multiplier bits remain after this shift.
    if (!is_div && mr[W-1:1] == '0)
      last = 1'b1;
`endif
  end

  always_ff @(posedge md_i_clk) begin
    if (!md_i_rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      acc    <= '0;
      mc     <= '0;
      mr     <= '0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.md_i_wr_hi)
            hi <= bus.md_i_wr_data;
          if (bus.md_i_wr_lo)
            lo <= bus.md_i_wr_data;
          if (bus.md_i_start && !bus.md_i_flush) begin
            state  <= CALC;
            cnt    <= '0;
            is_div <= bus.md_i_op[1];
            neg_q  <= sgn & (bus.md_i_data_rs[W-1] ^
                             bus.md_i_data_rt[W-1]);
            neg_r  <= sgn & bus.md_i_data_rs[W-1];
            dz     <= bus.md_i_op[1] &&
                      (bus.md_i_data_rt == '0);
            mr     <= rt_mag;
            if (bus.md_i_op[1]) begin
              acc <= {{W{1'b0}}, rs_mag};
              mc  <= {{W{1'b0}}, rt_mag};
            end else begin
              acc <= '0;
              mc  <= {{W{1'b0}}, rs_mag};
            end
          end
        end
        CALC: begin
          if (bus.md_i_flush) begin
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
            if (is_div) begin
              acc <= div_next;
            end else begin
              acc <= mul_next;
              mc  <= mc << 1;
              mr  <= mr >> 1;
            end
            if (last)
              state <= SIGN;
          end
        end
        SIGN: begin
          state <= IDLE;
          if (!bus.md_i_flush) begin
            done <= 1'b1;
            if (is_div) begin
              hi <= neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
              if (dz)
                lo <= '1;
              else
                lo <= neg_q ? -acc[W-1:0] : acc[W-1:0];
            end else begin
              {hi, lo} <= neg_q ? -acc : acc;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.md_o_hi   = hi;
  assign bus.md_o_lo   = lo;
  assign bus.md_o_busy = (state != IDLE);
  assign bus.md_o_done = done;
  assign bus.md_o_stall = bus.md_o_busy &
    (bus.md_i_start | bus.md_i_rd_hi | bus.md_i_rd_lo |
     bus.md_i_wr_hi | bus.md_i_wr_lo);
endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Randomised + directed bench for muldiv_hilo_ctrl against an
// arithmetic reference model of HI/LO, busy, done and stall.
module tb_muldiv_hilo_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad   = 0;

  muldiv_hilo_ctrl_if #(.DWIDTH(W)) bus ();

  muldiv_hilo_ctrl #(.DWIDTH(W), .CNT_WIDTH(6)) dut (
    .md_i_clk (clk),
    .md_i_rst (rst),
    .bus      (bus.slave)
  );

  always #5 clk = ~clk;

  // reference model state
  logic [W-1:0] m_hi, m_lo, m_rhi, m_rlo;
  bit           m_busy, m_done;
  int           m_rem;

  task automatic chk(string nm, logic [63:0] a, logic [63:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic ref_calc(logic [1:0] op, logic [W-1:0] rs,
                          logic [W-1:0] rt);
    longint       a, b, q, r;
    logic [63:0]  p;
    logic [W-1:0] mag;
    int           k;
    if (op[0]) begin
      a = longint'({32'b0, rs});
      b = longint'({32'b0, rt});
    end else begin
      a = longint'($signed(rs));
      b = longint'($signed(rt));
    end
    m_rem = W + 1;
    if (!op[1]) begin
      p = a * b;
      m_rhi = p[63:32];
      m_rlo = p[31:0];
`ifdef MD_EARLY_OUT_EN
      mag = (b < 0) ? W'(-b) : W'(b);
      k = 1;
      for (int i = 0; i < W; i++)
        if (mag[i]) k = i + 1;
      m_rem = k + 1;
`endif
    end else if (rt == '0) begin
      m_rhi = rs;
      m_rlo = '1;
    end else begin
      q = a / b;
      r = a % b;
      m_rhi = r[31:0];
      m_rlo = q[31:0];
    end
  endtask

  task automatic model_step();
    if (!rst) begin
      m_hi = '0; m_lo = '0;
      m_busy = 0; m_done = 0; m_rem = 0;
    end else begin
      m_done = 0;
      if (m_busy) begin
        if (bus.md_i_flush) begin
          m_busy = 0;
        end else begin
          m_rem--;
          if (m_rem == 0) begin
            m_hi = m_rhi; m_lo = m_rlo;
            m_busy = 0; m_done = 1;
          end
        end
      end else begin
        if (bus.md_i_wr_hi) m_hi = bus.md_i_wr_data;
        if (bus.md_i_wr_lo) m_lo = bus.md_i_wr_data;
        if (bus.md_i_start && !bus.md_i_flush) begin
          ref_calc(bus.md_i_op, bus.md_i_data_rs,
                   bus.md_i_data_rt);
          m_busy = 1;
        end
      end
    end
  endtask

  task automatic tick();
    logic req;
    #1;
    req = bus.md_i_start | bus.md_i_rd_hi | bus.md_i_rd_lo |
          bus.md_i_wr_hi | bus.md_i_wr_lo;
    chk("stall", bus.md_o_stall, m_busy & req);
    @(posedge clk);
    model_step();
    #1;
    chk("hi", bus.md_o_hi, m_hi);
    chk("lo", bus.md_o_lo, m_lo);
    chk("busy", bus.md_o_busy, m_busy);
    chk("done", bus.md_o_done, m_done);
  endtask

  task automatic clr();
    bus.md_i_start   = 0;
    bus.md_i_op      = 0;
    bus.md_i_data_rs = 0;
    bus.md_i_data_rt = 0;
    bus.md_i_flush   = 0;
    bus.md_i_rd_hi   = 0;
    bus.md_i_rd_lo   = 0;
    bus.md_i_wr_hi   = 0;
    bus.md_i_wr_lo   = 0;
    bus.md_i_wr_data = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (m_busy && n < 100) begin
      tick();
      n++;
    end
    chk("timeout", m_busy, 0);
    tick();
  endtask

  task automatic go(logic [1:0] op, logic [W-1:0] rs,
                    logic [W-1:0] rt);
    bus.md_i_start   = 1;
    bus.md_i_op      = op;
    bus.md_i_data_rs = rs;
    bus.md_i_data_rt = rt;
    tick();
    bus.md_i_start = 0;
  endtask

  initial begin
    clr();
    m_hi = '0; m_lo = '0; m_rhi = '0; m_rlo = '0;
    m_busy = 0; m_done = 0; m_rem = 0;
    rst = 0;
    tick(); tick();
    chk("rst_hi", bus.md_o_hi, 0);
    chk("rst_busy", bus.md_o_busy, 0);
    rst = 1;
    tick();

    // MULTU 5*4
    go(2'b01, 5, 4);
    chk("mulu_busy0", bus.md_o_busy, 1);
    wait_idle();
    chk("mulu_hi", bus.md_o_hi, 0);
    chk("mulu_lo", bus.md_o_lo, 20);

    // MULT -3*7
    go(2'b00, 32'hFFFFFFFD, 7);
    wait_idle();
    chk("mult_hi", bus.md_o_hi, 32'hFFFFFFFF);
    chk("mult_lo", bus.md_o_lo, 32'hFFFFFFEB);

    // DIV -7/2
    go(2'b10, 32'hFFFFFFF9, 2);
    wait_idle();
    chk("div_lo", bus.md_o_lo, 32'hFFFFFFFD);
    chk("div_hi", bus.md_o_hi, 32'hFFFFFFFF);

    // DIVU 7/0
    go(2'b11, 7, 0);
    wait_idle();
    chk("dz_lo", bus.md_o_lo, 32'hFFFFFFFF);
    chk("dz_hi", bus.md_o_hi, 7);

    // signed divide by zero keeps rs in HI
    go(2'b10, 32'hFFFFFFF0, 0);
    wait_idle();
    chk("sdz_lo", bus.md_o_lo, 32'hFFFFFFFF);
    chk("sdz_hi", bus.md_o_hi, 32'hFFFFFFF0);

    // overflow DIV
    go(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();
    chk("ovf_lo", bus.md_o_lo, 32'h80000000);
    chk("ovf_hi", bus.md_o_hi, 0);

    // MTHI then MULTU 3*3 with MFHI held
    bus.md_i_wr_hi = 1;
    bus.md_i_wr_data = 32'h1234;
    tick();
    clr();
    chk("mthi", bus.md_o_hi, 32'h1234);
    go(2'b01, 3, 3);
    bus.md_i_rd_hi = 1;
    for (int i = 0; i < 100 && m_busy; i++) tick();
    bus.md_i_rd_hi = 0;
    tick();
    chk("hold_hi", bus.md_o_hi, 0);
    chk("hold_lo", bus.md_o_lo, 9);

    // preload, DIVU 100/7, flush mid-op
    bus.md_i_wr_hi = 1;
    bus.md_i_wr_lo = 1;
    bus.md_i_wr_data = 32'hAA;
    tick();
    bus.md_i_wr_hi = 0;
    bus.md_i_wr_data = 32'hBB;
    tick();
    clr();
    go(2'b11, 100, 7);
    for (int i = 0; i < 9; i++) tick();
    bus.md_i_flush = 1;
    tick();
    bus.md_i_flush = 0;
    tick();
    chk("fl_busy", bus.md_o_busy, 0);
    chk("fl_hi", bus.md_o_hi, 32'hAA);
    chk("fl_lo", bus.md_o_lo, 32'hBB);

    // reset mid-op, then a fresh op
    go(2'b01, 1000, 1000);
    for (int i = 0; i < 4; i++) tick();
    rst = 0;
    tick();
    rst = 1;
    chk("mr_busy", bus.md_o_busy, 0);
    chk("mr_hi", bus.md_o_hi, 0);
    chk("mr_lo", bus.md_o_lo, 0);
    go(2'b01, 1000, 1000);
    wait_idle();
    chk("mr2_lo", bus.md_o_lo, 1000000);

    // randomised traffic
    for (int c = 0; c < 600; c++) begin
      bus.md_i_start = ($urandom % 4 == 0);
      bus.md_i_op    = 2'($urandom);
      bus.md_i_data_rs = ($urandom % 4 == 0) ?
        32'($urandom % 64) : $urandom;
      case ($urandom % 8)
        0:       bus.md_i_data_rt = 0;
        1, 2:    bus.md_i_data_rt = 32'($urandom % 300);
        3:       bus.md_i_data_rt = -32'($urandom % 5);
        default: bus.md_i_data_rt = $urandom;
      endcase
      bus.md_i_flush   = ($urandom % 40 == 0);
      bus.md_i_rd_hi   = ($urandom % 8 == 0);
      bus.md_i_rd_lo   = ($urandom % 8 == 0);
      bus.md_i_wr_hi   = ($urandom % 8 == 0);
      bus.md_i_wr_lo   = ($urandom % 8 == 0);
      bus.md_i_wr_data = $urandom;
      rst = ($urandom % 200 != 0);
      tick();
    end
    clr();
    rst = 1;
    tick();
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/muldiv_hilo_ctrl.md
Name: muldiv_hilo_ctrl

Overview:
- Sequencer for the iterative multiply/divide resource beside the EX-stage ALU.
- Accepts MULT/MULTU/DIV/DIVU from EX and runs a radix-2 shift-add / restoring-divide datapath for DWIDTH cycles.
- Owns the HI/LO architectural registers and services MFHI/MFLO/MTHI/MTLO.
- Raises a pipeline stall when any HI/LO access or new op arrives while an op is in flight.

Parameters:
- DWIDTH, default `DWIDTH (32): operand, HI and LO width.
- CNT_WIDTH, default 6: iteration counter width; must satisfy 2^CNT_WIDTH > DWIDTH.

Ports:
- md_i_clk  in  1  clock, rising edge.
- md_i_rst  in  1  synchronous, active-low reset.
- md_i_start  in  1  op request from EX.
- md_i_op  in  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- md_i_data_rs  in  DWIDTH  multiplicand / dividend.
- md_i_data_rt  in  DWIDTH  multiplier / divisor.
- md_i_flush  in  1  abort in-flight op (branch/exception flush).
- md_i_rd_hi, md_i_rd_lo  in  1 each  MFHI / MFLO request.
- md_i_wr_hi, md_i_wr_lo  in  1 each  MTHI / MTLO request.
- md_i_wr_data  in  DWIDTH  MTHI/MTLO data.
- md_o_hi, md_o_lo  out  DWIDTH  HI/LO register contents.
- md_o_busy  out  1  op in flight.
- md_o_done  out  1  one-cycle pulse when HI/LO are updated by an op.
- md_o_stall  out  1  stall request to the pipeline.

Behaviour:
- Reset (md_i_rst=0 at an edge), including mid-operation: state IDLE, HI=0, LO=0, busy=0, done=0, counter=0. The in-flight op is discarded.
- FSM states: IDLE, CALC, SIGN.
- IDLE -> CALC: md_i_start=1 at edge 0.
  - Latch op and operand magnitudes. For signed ops, take |x| in two's complement; -2^(DWIDTH-1) keeps its pattern, treated as unsigned.
  - Latch the result-sign flags and clear the counter.
- CALC: one iteration per edge, at edges 1..DWIDTH; counter increments each edge.
  - Multiply: shift-add, 2*DWIDTH-bit product.
  - Divide: restoring, 1 quotient bit per edge.
  - When counter reaches DWIDTH-1, the next edge goes to SIGN.
- SIGN, at edge DWIDTH+1:
  - Apply sign correction. Signed product is negated if the operand signs differ. Quotient is negated if signs differ. Remainder takes the dividend's sign.
  - Write HI (product upper half / remainder) and LO (product lower half / quotient).
  - Go to IDLE. md_o_done=1 for exactly the following cycle.
- Latency: new HI/LO visible on md_o_hi/md_o_lo DWIDTH+1 cycles after the start edge.
- md_o_busy=1 whenever state != IDLE.
- Divide by zero: full latency; LO = all ones, HI = dividend unchanged (rs).
- Overflow case DIV(-2^(DWIDTH-1), -1): LO = 0x80000000, HI = 0.
- md_o_stall is combinational: busy & (start | rd_hi | rd_lo | wr_hi | wr_lo).
  - md_i_start while busy is ignored; the requester holds it until accepted.
- MTHI/MTLO in IDLE write HI/LO at the edge. If a start is accepted at the same edge, both happen, and the op result overwrites HI/LO at completion.
- md_i_flush while busy: go to IDLE next edge, HI/LO unchanged, no done pulse. Flush in IDLE has no effect. Flush and start at the same edge: start is dropped.
- md_o_hi/md_o_lo are direct register outputs; reads never modify state.

Optional Feature:
- Macro: MD_EARLY_OUT_EN.
- Defined: for MULT/MULTU, CALC exits to SIGN after the edge at which the remaining unshifted multiplier magnitude becomes zero. There is always at least one CALC edge.
  - HI/LO are written at edge k+1, where k = max(1, index of the highest set bit of |rt| + 1).
  - Divides are unaffected.
- Undefined: all ops take the fixed DWIDTH+1 latency.

Test Plan:
- Reset, then MULTU rs=5 rt=4 -> busy 1 for edges 0..32, HI=0 LO=20 after edge 33, done pulse for one cycle (with MD_EARLY_OUT_EN: result after edge 4).
- MULT rs=0xFFFFFFFD (-3) rt=7 -> HI=0xFFFFFFFF LO=0xFFFFFFEB.
- DIV rs=0xFFFFFFF9 (-7) rt=2 -> LO=0xFFFFFFFD HI=0xFFFFFFFF; DIVU rs=7 rt=0 -> LO=0xFFFFFFFF HI=7.
- MTHI 0x1234 in IDLE, then MULTU 3*3, hold md_i_rd_hi during busy -> stall=1 every busy cycle, drops after done; HI=0 LO=9.
- Preload HI=0xAA, LO=0xBB; start DIVU 100/7, flush at edge 10 -> busy=0 after edge 11, no done, HI/LO stay 0xAA/0xBB.
- Start MULTU, assert md_i_rst=0 at edge 5 -> HI=LO=0, busy=0 next cycle; a new start afterwards completes normally.
